ps2_host_tx: RTL

- PS/2 host-to-device transmitter. It sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- It is the opposite direction of the existing keyboard PS/2 receive path and shares the PS2_CLK/PS2_DATA open-drain lines with it.
- Runs in the 100 MHz board clock domain. Exports open-drain enables; the top level builds the tristate (line driven 0 when enable=1, else Z).
- Asserts busy so the receive path ignores line activity during a host transmission.

---
 rtl/ps2_host_tx.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 10 device-clocked bits, ACK check.
// Latency: INHIBIT_CYC+2 cycles to clock release, then paced by the device clock (~1 ms per byte at 12.5 kHz).
// Backpressure: tx_ready only in IDLE; tx_valid while busy is dropped, never queued. Optional: PS2_TX_RETRY_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYC     = 10000,
    parameter int REQ_TIMEOUT_CYC = 1500000,
    parameter int PKT_TIMEOUT_CYC = 200000,
    parameter int RETRY_MAX       = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_REQ,
        S_DATA,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam logic [20:0] INH_LAST = 21'(INHIBIT_CYC - 1);
    localparam logic [20:0] REQ_TO   = 21'(REQ_TIMEOUT_CYC);
    localparam logic [20:0] PKT_TO   = 21'(PKT_TIMEOUT_CYC);
    localparam logic [3:0]  RETRY_LIM = 4'(RETRY_MAX);
`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    localparam logic [1:0] ERR_REQ = 2'b01;
    localparam logic [1:0] ERR_PKT = 2'b10;
    localparam logic [1:0] ERR_ACK = 2'b11;

    // Synchronizers: [0]=s1, [1]=s2, [2]=s3 (clock only needs s3 for edge detect)
    logic [2:0] clk_sync_q, clk_sync_d;
    logic [1:0] data_sync_q, data_sync_d;

    state_t      state_q, state_d;
    logic [20:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]  idx_q, idx_d;
    logic [9:0]  frame_q, frame_d;
    logic [3:0]  retry_q, retry_d;
    logic        clk_oe_q, clk_oe_d;
    logic        data_oe_q, data_oe_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic       clk_fall;
    logic       clk_s2;
    logic       data_s2;
    logic       fail;
    logic [1:0] fail_code;

    assign clk_s2   = clk_sync_q[1];
    assign data_s2  = data_sync_q[1];
    assign clk_fall = ~clk_sync_q[1] & clk_sync_q[2];

    // Shift the raw line levels into the synchronizer chains
    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk_i};
        data_sync_d = {data_sync_q[0], ps2_data_i};
    end

    // Synchronizer flops idle high so reset never produces a false falling edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
        end
    end

    // Saturating cycle counter shared by inhibit, request and packet timing
    always_comb begin
        cnt_inc = (cnt_q == {21{1'b1}}) ? cnt_q : cnt_q + 21'd1;
    end

    // Next-state logic for the transmit FSM and its registered outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        idx_d      = idx_q;
        frame_d    = frame_q;
        retry_d    = retry_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        fail       = 1'b0;
        fail_code  = 2'b00;

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                cnt_d     = '0;
                if (tx_valid) begin
                    // Frame is {stop, odd parity, data}, shifted out LSB first
                    frame_d  = {1'b1, ~^tx_data, tx_data};
                    idx_d    = '0;
                    retry_d  = '0;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                // Counter starts at 1 so REQ_TO equals cycles since clock release
                clk_oe_d = 1'b0;
                cnt_d    = 21'd1;
                state_d  = S_REQ;
            end
            S_REQ: begin
                if (clk_fall) begin
                    data_oe_d = ~frame_q[0];
                    idx_d     = 4'd1;
                    cnt_d     = 21'd1;
                    state_d   = S_DATA;
                end else if (cnt_q >= REQ_TO) begin
                    fail      = 1'b1;
                    fail_code = ERR_REQ;
                end
            end
            S_DATA: begin
                if (cnt_q >= PKT_TO) begin
                    fail      = 1'b1;
                    fail_code = ERR_PKT;
                end else if (clk_fall) begin
                    data_oe_d = ~frame_q[idx_q];
                    idx_d     = idx_q + 4'd1;
                    if (idx_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (cnt_q >= PKT_TO) begin
                    fail      = 1'b1;
                    fail_code = ERR_PKT;
                end else if (clk_fall) begin
                    if (data_s2) begin
                        fail      = 1'b1;
                        fail_code = ERR_ACK;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (cnt_q >= PKT_TO) begin
                    fail      = 1'b1;
                    fail_code = ERR_PKT;
                end else if (clk_s2 && data_s2) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // Any failure releases both lines; either retry from inhibit or report
        if (fail) begin
            data_oe_d = 1'b0;
            if (RETRY_ON && (retry_q < RETRY_LIM)) begin
                retry_d  = retry_q + 4'd1;
                clk_oe_d = 1'b1;
                cnt_d    = '0;
                idx_d    = '0;
                state_d  = S_INHIBIT;
            end else begin
                clk_oe_d   = 1'b0;
                err_d      = 1'b1;
                err_code_d = fail_code;
                state_d    = S_IDLE;
            end
        end
    end

    // FSM state and registered outputs; reset releases both lines immediately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            frame_q    <= '0;
            retry_q    <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            retry_q    <= retry_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign err_code    = err_code_q;

endmodule
